// File: rtl/hc_sr04_emulator.sv
`timescale 1ns/1ps
// hc_sr04_emulator: sensor-side HC-SR04 model answering a trig pulse with a distance-encoded echo
//   clk          in   clock (100 MHz nominal)
//   rst          in   asynchronous active-low reset
//   trig         in   trigger from the ranging interface, asynchronous to clk
//   distance_cm  in   programmed target distance, 0 means no object
//   echo         out  echo pulse, width = distance * cycles_per_cm or timeout
//   busy         out  high in every state except IDLE
//   short_trig   out  one-cycle pulse when a trig is rejected as too short
//   state        out  current FSM state for debug
//   meas_count   out  completed echo pulses, wrapping
module hc_sr04_emulator #(
   parameter int ten_us         = 1000,
   parameter int burst_cycles   = 20000,
   parameter int cycles_per_cm  = 5800,
   parameter int max_cm         = 400,
   parameter int timeout_cycles = 3800000,
   parameter int holdoff_cycles = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trig,
   input  logic [8:0]  distance_cm,
   output logic        echo,
   output logic        busy,
   output logic        short_trig,
   output logic [2:0]  state,
   output logic [15:0] meas_count
);
   // one shared cycle counter covers BURST, timeout ECHO and HOLDOFF
   localparam int cmax = burst_cycles > timeout_cycles ?
                         (burst_cycles > holdoff_cycles ? burst_cycles : holdoff_cycles) :
                         (timeout_cycles > holdoff_cycles ? timeout_cycles : holdoff_cycles);
   localparam int cw = cmax > 1 ? $clog2(cmax) : 1;
   localparam int ww = $clog2(ten_us + 1) > 0 ? $clog2(ten_us + 1) : 1;
   localparam int sw = cycles_per_cm > 1 ? $clog2(cycles_per_cm) : 1;
   typedef enum logic [2:0] {IDLE = 3'd0, TRIGHI = 3'd1, BURST = 3'd2, ECHO = 3'd3, HOLDOFF = 3'd4} state_t;
   state_t        state_q;
   logic [1:0]    sync_q;
   logic [ww-1:0] wcnt_q;
   logic [cw-1:0] cnt_q;
   logic [sw-1:0] sub_q;
   logic [8:0]    cm_q;
   logic          noobj_q;
   logic          echo_q;
   logic          short_q;
   logic [15:0]   meas_q;
   logic          trig_s;
   logic          sub_end;
   assign trig_s     = sync_q[1];
   assign sub_end    = sub_q == sw'(cycles_per_cm - 1);
   assign echo       = echo_q;
   assign short_trig = short_q;
   assign state      = state_q;
   assign busy       = state_q != IDLE;
   assign meas_count = meas_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sync_q  <= '0;
         wcnt_q  <= '0;
         cnt_q   <= '0;
         sub_q   <= '0;
         cm_q    <= '0;
         noobj_q <= 1'b0;
         echo_q  <= 1'b0;
         short_q <= 1'b0;
         meas_q  <= '0;
      end else begin
         sync_q  <= {sync_q[0], trig};
         short_q <= 1'b0;
         cnt_q   <= cnt_q + 1'b1;
         case (state_q)
            IDLE: if (trig_s) begin
               state_q <= TRIGHI;
               wcnt_q  <= ww'(1);
            end
            TRIGHI: if (trig_s) begin
               if (wcnt_q < ww'(ten_us)) wcnt_q <= wcnt_q + 1'b1;
            end else if (wcnt_q >= ww'(ten_us)) begin
               // cm_q doubles as the latched distance; later distance_cm changes are ignored
               cm_q    <= distance_cm;
               noobj_q <= distance_cm == 9'd0 || distance_cm > 9'(max_cm);
               cnt_q   <= '0;
               state_q <= BURST;
            end else begin
               short_q <= 1'b1;
               state_q <= IDLE;
            end
            BURST: if (cnt_q == cw'(burst_cycles - 1)) begin
               state_q <= ECHO;
               echo_q  <= 1'b1;
               cnt_q   <= '0;
               sub_q   <= '0;
            end
            ECHO: begin
               sub_q <= sub_end ? '0 : sub_q + 1'b1;
               if (sub_end) cm_q <= cm_q - 9'd1;
               if (noobj_q ? cnt_q == cw'(timeout_cycles - 1) : sub_end && cm_q == 9'd1) begin
                  echo_q  <= 1'b0;
                  meas_q  <= meas_q + 16'd1;
                  cnt_q   <= '0;
                  state_q <= HOLDOFF;
               end
            end
            HOLDOFF: if (cnt_q == cw'(holdoff_cycles - 1)) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hc_sr04_emulator.sv
`timescale 1ns/1ps
// tb_hc_sr04_emulator: directed checks of the HC-SR04 emulator with small timing parameters
module tb_hc_sr04_emulator;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        trig = 1'b0;
   logic [8:0]  distance_cm = 9'd37;
   logic        echo;
   logic        busy;
   logic        short_trig;
   logic [2:0]  state;
   logic [15:0] meas_count;
   int checks = 0;
   int failures = 0;
   int short_cnt = 0;
   int rises = 0;
   logic echo_prev = 1'b0;
   int lat, wid, hold, s0, r0;
   hc_sr04_emulator #(
      .ten_us(10), .burst_cycles(20), .cycles_per_cm(5),
      .max_cm(400), .timeout_cycles(1000), .holdoff_cycles(50)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
      .echo(echo), .busy(busy), .short_trig(short_trig),
      .state(state), .meas_count(meas_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (short_trig) short_cnt <= short_cnt + 1;
      if (echo && !echo_prev) rises <= rises + 1;
      echo_prev <= echo;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic pulse(input int n);
      @(negedge clk) trig = 1'b1;
      repeat (n) @(negedge clk);
      trig = 1'b0;
   endtask
   task automatic wait_st(input logic [2:0] s);
      int n = 0;
      while (state != s && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (state != s) chk("wait_state_timeout", 32'(state), 32'(s));
   endtask
   // lat: cycles from BURST entry to echo rise; wid: echo high cycles; hold: busy cycles after echo fall
   task automatic measure(output int l, output int w, output int h);
      int n = 0;
      l = -1; w = -1; h = -1;
      while (state != 3'd2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (state != 3'd2) begin
         chk("burst_entry_timeout", 32'(state), 32'd2);
         return;
      end
      l = 0;
      while (!echo && l < 100) begin
         @(negedge clk);
         l++;
      end
      w = 0;
      while (echo && w < 2000) begin
         @(negedge clk);
         w++;
      end
      h = 0;
      while (busy && h < 200) begin
         @(negedge clk);
         h++;
      end
   endtask
   task automatic disturb();
      wait_st(3'd2);
      pulse(3);
      wait_st(3'd3);
      repeat (30) @(negedge clk);
      distance_cm = 9'd100;
      pulse(4);
      wait_st(3'd4);
      pulse(3);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_echo", 32'(echo), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_short", 32'(short_trig), 32'd0);
      chk("rst_meas", 32'(meas_count), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      pulse(12);
      measure(lat, wid, hold);
      chk("norm_lat", 32'(lat), 32'd20);
      chk("norm_width", 32'(wid), 32'd185);
      chk("norm_hold", 32'(hold), 32'd50);
      chk("norm_meas", 32'(meas_count), 32'd1);
      s0 = short_cnt; r0 = rises;
      pulse(5);
      repeat (6) @(negedge clk);
      chk("short5_pulse", 32'(short_cnt - s0), 32'd1);
      chk("short5_state", 32'(state), 32'd0);
      pulse(9);
      repeat (6) @(negedge clk);
      chk("short9_pulse", 32'(short_cnt - s0), 32'd2);
      chk("short_no_echo", 32'(rises - r0), 32'd0);
      chk("short_meas", 32'(meas_count), 32'd1);
      distance_cm = 9'd0;
      pulse(11);
      measure(lat, wid, hold);
      chk("noobj0_width", 32'(wid), 32'd1000);
      distance_cm = 9'd401;
      pulse(10);
      measure(lat, wid, hold);
      chk("noobj401_width", 32'(wid), 32'd1000);
      chk("noobj_meas", 32'(meas_count), 32'd3);
      distance_cm = 9'd37;
      pulse(12);
      s0 = short_cnt; r0 = rises;
      fork
         measure(lat, wid, hold);
         disturb();
      join
      repeat (4) @(negedge clk);
      chk("ign_width", 32'(wid), 32'd185);
      chk("ign_rises", 32'(rises - r0), 32'd1);
      chk("ign_short", 32'(short_cnt - s0), 32'd0);
      chk("ign_state", 32'(state), 32'd0);
      chk("ign_meas", 32'(meas_count), 32'd4);
      distance_cm = 9'd37;
      pulse(12);
      wait_st(3'd3);
      repeat (50) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_echo", 32'(echo), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_meas", 32'(meas_count), 32'd0);
      @(negedge clk) rst = 1'b1;
      pulse(12);
      measure(lat, wid, hold);
      chk("post_rst_width", 32'(wid), 32'd185);
      chk("post_rst_meas", 32'(meas_count), 32'd1);
      @(negedge clk) trig = 1'b1;
      repeat (40) @(negedge clk);
      chk("held_state", 32'(state), 32'd1);
      chk("held_echo", 32'(echo), 32'd0);
      trig = 1'b0;
      measure(lat, wid, hold);
      chk("held_width", 32'(wid), 32'd185);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      distance_cm = 9'd25;
      for (int i = 0; i < 3; i++) begin
         pulse(12);
         measure(lat, wid, hold);
         chk("loop_cm", 32'(wid / 5), 32'd25);
      end
      chk("loop_meas", 32'(meas_count), 32'd3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
